// File: rtl/uart_pkg.sv
// Shared UART constants: frame geometry and the TX/RX state encodings.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Transmit state encoding
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Receive state encoding
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Word placed on the 16-bit bus when the receive buffer is read
    function automatic logic [15:0] bus_word(input logic [UART_DATA_BITS-1:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Serial receiver: 2-FF synchronizer, start-bit validation at mid-bit,
// eight LSB-first data samples and a stop-bit check. Emits one-cycle
// rx_valid (good stop bit) or rx_ferr (stop bit low) pulses.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_valid,
    output logic                      rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      sync1;
    logic                      sync2;
    logic                      line_prev;
    logic [1:0]                state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      baud_end;

    assign baud_end = (cnt == CNT_FULL);

    // Synchronize the asynchronous line; flops reset to the idle (high) level
    // so that leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= rxd;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    // Receive state machine with baud counter, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (line_prev && !sync2) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check the line half a bit in; a high level means a glitch.
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_end) begin
                        cnt   <= '0;
                        shreg <= {sync2, shreg[UART_DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (baud_end) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // The stop-bit sample is used combinationally so the top can register
    // the completed byte in the same cycle the stop bit is judged.
    assign rx_byte  = shreg;
    assign rx_valid = (state == RX_STOP) && baud_end && sync2;
    assign rx_ferr  = (state == RX_STOP) && baud_end && !sync2;

endmodule

// File: rtl/uart_responder.sv
// Bus-side UART model: answers wrn/rdn strobes on the shared 16-bit bus,
// serializes written bytes onto txd (8N1) and buffers received bytes.
module uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [15:0] data_io,
    input  logic        wrn,
    input  logic        rdn,
    output logic        data_ready,
    output logic        tbre,
    output logic        tsre,
    output logic        txd,
    input  logic        rxd,
    output logic        overrun,
    output logic        frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      wrn_q;
    logic                      rdn_q;
    logic                      wr_edge;
    logic                      rd_edge;
    logic [UART_DATA_BITS-1:0] thr;
    logic [UART_DATA_BITS-1:0] tsr;
    logic [UART_DATA_BITS-1:0] rbr;
    logic [1:0]                tx_state;
    logic [CNT_W-1:0]          tx_cnt;
    logic [2:0]                tx_bit;
    logic                      tx_baud_end;
    logic                      tx_consume;
    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_valid;
    logic                      rx_ferr;

    uart_rx_fsm #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (CLK),
        .rst_n   (RST),
        .rxd     (rxd),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    // Receive buffer is visible on the bus for as long as rdn is held low.
    assign data_io = (!rdn) ? bus_word(rbr) : 16'hzzzz;

    assign wr_edge     = !wrn_q && wrn;
    assign rd_edge     = !rdn_q && rdn;
    assign tx_baud_end = (tx_cnt == CNT_FULL);
    // The transmitter takes the holding byte when idle or at the very end of
    // a stop bit, which is what makes back-to-back frames gapless.
    assign tx_consume  = !tbre &&
                         ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_baud_end));

    // Register the strobes for rising-edge detection
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wrn_q <= 1'b1;
            rdn_q <= 1'b1;
        end else begin
            wrn_q <= wrn;
            rdn_q <= rdn;
        end
    end

    // Transmit holding register: a new write wins over a same-cycle consume
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            thr  <= '0;
            tbre <= 1'b1;
        end else if (wr_edge) begin
            thr  <= data_io[UART_DATA_BITS-1:0];
            tbre <= 1'b0;
        end else if (tx_consume) begin
            tbre <= 1'b1;
        end
    end

    // Transmit state machine driving a registered txd
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tsr      <= '0;
            tsre     <= 1'b1;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_consume) begin
                        tsr      <= thr;
                        tsre     <= 1'b0;
                        txd      <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_baud_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tsr[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_baud_end) begin
                        tx_cnt <= '0;
                        tsr    <= {1'b0, tsr[UART_DATA_BITS-1:1]};
                        if (tx_bit == LAST_BIT) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            txd    <= tsr[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_baud_end) begin
                        tx_cnt <= '0;
                        if (tx_consume) begin
                            tsr      <= thr;
                            txd      <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tsre     <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Receive buffer and sticky status flags; a completing byte beats a
    // same-cycle read, and that read does not count as an overrun.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rbr        <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rx_valid) begin
                rbr        <= rx_byte;
                data_ready <= 1'b1;
            end else if (rd_edge) begin
                data_ready <= 1'b0;
            end
            if ((wr_edge && !tbre && !tx_consume) ||
                (rx_valid && data_ready && !rd_edge)) begin
                overrun <= 1'b1;
            end
            if (rx_ferr) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_responder.sv
// Scoreboard bench for uart_responder: stimulus pushes expected bytes,
// a line decoder and a bus reader pop and compare independently.
module tb_uart_responder;

    localparam int C = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        wrn = 1'b1;
    logic        rdn = 1'b1;
    logic        rxd = 1'b1;
    logic        bus_en = 1'b0;
    logic [15:0] bus_drv = 16'h0000;
    wire  [15:0] data_io;
    logic        data_ready;
    logic        tbre;
    logic        tsre;
    logic        txd;
    logic        overrun;
    logic        frame_err;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rx_m = 0;
    int          dr_cyc = 0;
    logic        mon_en = 1'b1;
    logic        auto_read = 1'b1;
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_exp[$];
    int          tx_start_q[$];

    assign data_io = bus_en ? bus_drv : 16'hzzzz;

    uart_responder #(.CLKS_PER_BIT(C)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .data_io   (data_io),
        .wrn       (wrn),
        .rdn       (rdn),
        .data_ready(data_ready),
        .tbre      (tbre),
        .tsre      (tsre),
        .txd       (txd),
        .rxd       (rxd),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Bus write: byte latched when wrn returns high, bus held one more cycle
    task automatic do_write(input logic [7:0] b);
        @(negedge CLK);
        bus_drv = {8'h00, b};
        bus_en  = 1'b1;
        wrn     = 1'b0;
        @(negedge CLK);
        wrn = 1'b1;
        @(negedge CLK);
        bus_en = 1'b0;
    endtask

    // Drive one 8N1 frame on rxd with a chosen stop-bit level
    task automatic send_rx(input logic [7:0] b, input logic stopb);
        @(negedge CLK);
        rx_m = cyc;
        rxd  = 1'b0;
        repeat (C) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge CLK);
        end
        rxd = stopb;
        repeat (C) @(negedge CLK);
        rxd = 1'b1;
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (!(tsre === 1'b1 && tbre === 1'b1) && n < 40 * C) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40 * C) fail_now("tx_idle_timeout");
    endtask

    task automatic wait_rx_drain();
        int n;
        n = 0;
        while (rx_exp.size() != 0 && n < 30 * C) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 30 * C) fail_now("rx_drain_timeout");
        repeat (4) @(negedge CLK);
    endtask

    task automatic rx_frame_checked(input logic [7:0] b);
        int lat;
        rx_exp.push_back(b);
        send_rx(b, 1'b1);
        wait_rx_drain();
        lat = dr_cyc - rx_m;
        check("rx_latency_in_window", 32'((lat <= 3 + (19 * C) / 2) && (lat >= 9 * C)), 32'd1);
    endtask

    // Line decoder: samples each frame at mid-bit and scores the byte
    initial begin
        int         st;
        logic [7:0] b;
        logic       sb;
        logic       stp;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && txd === 1'b0) begin
                st = cyc;
                repeat (C / 2) @(negedge CLK);
                sb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge CLK);
                    b[i] = txd;
                end
                repeat (C) @(negedge CLK);
                stp = txd;
                if (mon_en) begin
                    check("tx_start_bit", 32'(sb), 32'd0);
                    check("tx_stop_bit", 32'(stp), 32'd1);
                    if (tx_exp.size() == 0) begin
                        fail_now("tx_unexpected_frame");
                    end else begin
                        check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
                    end
                    tx_start_q.push_back(st);
                end
            end
        end
    end

    // Bus reader: reads whenever a byte is ready and scores it
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (auto_read && RST === 1'b1 && data_ready === 1'b1) begin
                dr_cyc = cyc;
                rdn = 1'b0;
                #1;
                if (rx_exp.size() == 0) begin
                    fail_now("rx_unexpected_byte");
                end else begin
                    e = rx_exp.pop_front();
                    check("rx_read_data", 32'(data_io), {16'h0000, 8'h00, e});
                end
                @(negedge CLK);
                rdn = 1'b1;
                @(negedge CLK);
                check("rx_ready_cleared", 32'(data_ready), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] b2;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_tbre", 32'(tbre), 32'd1);
        check("rst_tsre", 32'(tsre), 32'd1);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        // Single write: tbre dips one cycle, start bit at N+2, tsre back at N+2+10C
        tx_exp.push_back(8'hA5);
        do_write(8'hA5);
        check("a5_tbre_low", 32'(tbre), 32'd0);
        @(negedge CLK);
        check("a5_tbre_back", 32'(tbre), 32'd1);
        check("a5_tsre_low", 32'(tsre), 32'd0);
        check("a5_txd_start", 32'(txd), 32'd0);
        repeat (10 * C - 1) @(negedge CLK);
        check("a5_tsre_before_end", 32'(tsre), 32'd0);
        @(negedge CLK);
        check("a5_tsre_at_end", 32'(tsre), 32'd1);
        wait_tx_idle();

        // Back-to-back frames, second write while the first is shifting
        tx_exp.push_back(8'h41);
        tx_exp.push_back(8'h42);
        do_write(8'h41);
        repeat (20) @(negedge CLK);
        do_write(8'h42);
        wait_tx_idle();
        repeat (4) @(negedge CLK);
        if (tx_start_q.size() >= 2)
            check("b2b_no_gap", 32'(tx_start_q[$] - tx_start_q[$-1]), 32'(10 * C));
        else
            fail_now("b2b_frames_missing");
        check("b2b_overrun", 32'(overrun), 32'd0);
        check("b2b_tx_drained", 32'(tx_exp.size()), 32'd0);

        // Receive 8'h3C and read it back over the bus
        rx_frame_checked(8'h3C);
        check("rx3c_overrun", 32'(overrun), 32'd0);

        // Randomized transmit traffic
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            tx_exp.push_back(b);
            do_write(b);
            wait_tx_idle();
            repeat ($urandom_range(0, 20)) @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
        check("rand_tx_drained", 32'(tx_exp.size()), 32'd0);

        // Randomized receive traffic
        for (int i = 0; i < 4; i++) begin
            rx_frame_checked(8'($urandom));
            repeat ($urandom_range(0, 30)) @(negedge CLK);
        end
        check("rand_flags_overrun", 32'(overrun), 32'd0);
        check("rand_flags_frame_err", 32'(frame_err), 32'd0);

        // Short low glitch on rxd is a false start
        @(negedge CLK);
        rxd = 1'b0;
        repeat (4) @(negedge CLK);
        rxd = 1'b1;
        repeat (12 * C) @(negedge CLK);
        check("glitch_data_ready", 32'(data_ready), 32'd0);
        check("glitch_frame_err", 32'(frame_err), 32'd0);
        check("glitch_overrun", 32'(overrun), 32'd0);

        // Three writes inside one frame time: the middle byte is lost
        tx_exp.push_back(8'h11);
        tx_exp.push_back(8'h33);
        do_write(8'h11);
        do_write(8'h22);
        do_write(8'h33);
        wait_tx_idle();
        repeat (4) @(negedge CLK);
        check("tx_ovr_flag", 32'(overrun), 32'd1);
        check("tx_ovr_drained", 32'(tx_exp.size()), 32'd0);

        // Reset clears the sticky flag
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rerst_overrun", 32'(overrun), 32'd0);

        // Two received bytes without a read: second wins, overrun set
        auto_read = 1'b0;
        b  = 8'($urandom);
        b2 = 8'($urandom);
        send_rx(b, 1'b1);
        send_rx(b2, 1'b1);
        repeat (5) @(negedge CLK);
        check("rx_ovr_ready", 32'(data_ready), 32'd1);
        check("rx_ovr_flag", 32'(overrun), 32'd1);
        rx_exp.push_back(b2);
        auto_read = 1'b1;
        wait_rx_drain();

        // Stop bit sampled low: frame error, nothing delivered
        send_rx(8'($urandom), 1'b0);
        repeat (20) @(negedge CLK);
        check("ferr_flag", 32'(frame_err), 32'd1);
        check("ferr_no_ready", 32'(data_ready), 32'd0);

        // Reset in the middle of a transmit frame
        mon_en = 1'b0;
        do_write(8'h55);
        repeat (3 * C) @(negedge CLK);
        check("midtx_txd_busy", 32'(tsre), 32'd0);
        RST = 1'b0;
        #1;
        check("midtx_rst_txd", 32'(txd), 32'd1);
        check("midtx_rst_tsre", 32'(tsre), 32'd1);
        check("midtx_rst_tbre", 32'(tbre), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
